// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch stage: instruction/opcode field
// geometry, the bubble encoding and the sequential PC increment.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int OP_W    = 11;
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 21;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
    localparam int PC_INC  = 4;

endpackage

// File: rtl/fetch_stage_flopre.sv
// Module flopre: W-bit register with load enable and an asynchronous
// active-low reset to RESET_VAL. Holds the program counter.
module flopre #(
    parameter int             W         = 64,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= RESET_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction memory addressing and the
// IF/ID pipeline register. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int           N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               pc_src,
    input  logic [N-1:0]       branch_target,
    output logic [N-1:0]       imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [N-1:0]       if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid,
    output logic [OP_W-1:0]    op
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        bubble_cnt
`endif
);

    logic [N-1:0] pc_p0;
    logic [N-1:0] pc_next_p0;
    logic         pc_en_p0;
    logic         started;
    logic         load_bubble;
    logic         load_instr;

    // Low for the first edge after reset release, so that edge is a plain
    // fetch of RESET_PC whatever the redirect/stall/flush inputs say.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            started <= 1'b0;
        else
            started <= 1'b1;
    end

    always_comb begin
        load_bubble = started & (flush | pc_src);
        load_instr  = ~load_bubble & (~started | ~stall);
        pc_en_p0    = ~started | pc_src | ~stall;
        pc_next_p0  = (started & pc_src) ? branch_target : pc_p0 + N'(PC_INC);
    end

    flopre #(
        .W         (N),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en_p0),
        .d     (pc_next_p0),
        .q     (pc_p0)
    );

    assign imem_addr = pc_p0;

    // IF/ID boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (load_bubble) begin
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (load_instr) begin
            if_id_pc    <= pc_p0;
            if_id_instr <= imem_data;
            if_id_valid <= 1'b1;
        end
    end

    assign op = if_id_instr[OP_MSB:OP_LSB];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (load_instr)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (load_bubble)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage; counter checks are compiled in only
// when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        pc_src;
    logic [63:0] branch_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [10:0] op;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    int vectors = 0;
    int miss    = 0;

    fetch_stage #(.N(64), .RESET_PC(64'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .op            (op)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt     (fetch_cnt),
        .bubble_cnt    (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word at address a is a[31:0] ^ 32'hF840_0000.
    assign imem_data = imem_addr[31:0] ^ 32'hF840_0000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [63:0] addr, input logic [63:0] ipc,
                            input logic [31:0] instr, input logic vld, input logic [10:0] opx);
        chk({tag, ".addr"},  imem_addr, addr);
        chk({tag, ".ifpc"},  if_id_pc, ipc);
        chk({tag, ".instr"}, {32'h0, if_id_instr}, {32'h0, instr});
        chk({tag, ".valid"}, {63'h0, if_id_valid}, {63'h0, vld});
        chk({tag, ".op"},    {53'h0, op}, {53'h0, opx});
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 1'b0; branch_target = '0;
        repeat (2) tick();
        chk_ifid("por", 64'h0, 64'h0, 32'h0, 1'b0, 11'h0);

        // Release mid-cycle; first edge fetches address 0.
        #2 reset = 1'b1;
        tick();
        chk_ifid("first", 64'h4, 64'h0, 32'hF840_0000, 1'b1, 11'b11111000010);
        tick();
        chk_ifid("seq2", 64'h8, 64'h4, 32'hF840_0004, 1'b1, 11'b11111000010);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ifid("stall", 64'h8, 64'h4, 32'hF840_0004, 1'b1, 11'b11111000010);
        end
        stall = 1'b0;
        tick();
        chk_ifid("unstall", 64'hC, 64'h8, 32'hF840_0008, 1'b1, 11'b11111000010);
        tick();
        chk_ifid("seq4", 64'h10, 64'hC, 32'hF840_000C, 1'b1, 11'b11111000010);

        // Redirect wins over stall.
        stall = 1'b1; pc_src = 1'b1; branch_target = 64'h40;
        tick();
        chk_ifid("redir", 64'h40, 64'h0, 32'h0, 1'b0, 11'h0);
        stall = 1'b0; pc_src = 1'b0;
        tick();
        chk_ifid("postredir", 64'h44, 64'h40, 32'hF840_0040, 1'b1, 11'b11111000010);

        flush = 1'b1;
        tick();
        chk_ifid("flush", 64'h48, 64'h0, 32'h0, 1'b0, 11'h0);
        flush = 1'b0;
        tick();
        chk_ifid("postflush", 64'h4C, 64'h48, 32'hF840_0048, 1'b1, 11'b11111000010);

        // PC wraps modulo 2^64.
        pc_src = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        chk("wrap.pre", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        pc_src = 1'b0;
        tick();
        chk_ifid("wrap", 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h07BF_FFFC, 1'b1, 11'h03D);
        tick();
        chk("run.addr", imem_addr, 64'h4);

        // Asynchronous reset mid-run, with redirect/stall pending at release.
        #2 reset = 1'b0;
        #1;
        chk_ifid("async", 64'h0, 64'h0, 32'h0, 1'b0, 11'h0);
        stall = 1'b1; pc_src = 1'b1; branch_target = 64'h80; flush = 1'b1;
        tick();
        chk_ifid("inrst", 64'h0, 64'h0, 32'h0, 1'b0, 11'h0);
        #2 reset = 1'b1;
        tick();
        chk_ifid("rel", 64'h4, 64'h0, 32'hF840_0000, 1'b1, 11'b11111000010);
        stall = 1'b0; pc_src = 1'b0;

        // From this reset: flush, fetch, fetch, flush, fetch, fetch.
        tick();
        chk_ifid("cflush1", 64'h8, 64'h0, 32'h0, 1'b0, 11'h0);
        flush = 1'b0;
        tick();
        tick();
        chk_ifid("cfetch3", 64'h10, 64'hC, 32'hF840_000C, 1'b1, 11'b11111000010);
        flush = 1'b1;
        tick();
        chk_ifid("cflush2", 64'h14, 64'h0, 32'h0, 1'b0, 11'h0);
        flush = 1'b0;
        tick();
        tick();
        chk_ifid("cfetch5", 64'h1C, 64'h18, 32'hF840_0018, 1'b1, 11'b11111000010);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", {32'h0, fetch_cnt}, 64'd5);
        chk("bubble_cnt", {32'h0, bubble_cnt}, 64'd2);
        #2 reset = 1'b0;
        #1;
        chk("fetch_cnt.rst", {32'h0, fetch_cnt}, 64'd0);
        chk("bubble_cnt.rst", {32'h0, bubble_cnt}, 64'd0);
        reset = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter N, default 64, datapath and PC width in bits.
REQ-002 SHALL have parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-006 SHALL have port flush  input  1  replace next IF/ID contents with a bubble.
REQ-007 SHALL have port pc_src  input  1  redirect PC to branch_target.
REQ-008 SHALL have port branch_target  input  N  redirect address.
REQ-009 SHALL have port imem_addr  output  N  instruction memory address, equal to current PC.
REQ-010 SHALL have port imem_data  input  32  instruction word, combinational read of imem_addr.
REQ-011 SHALL have port if_id_pc  output  N  PC of the instruction held in IF/ID.
REQ-012 SHALL have port if_id_instr  output  32  instruction held in IF/ID.
REQ-013 SHALL have port if_id_valid  output  1  IF/ID holds a real instruction.
REQ-014 SHALL have port op  output  11  if_id_instr[31:21], fed to the main decoder.

Function
REQ-015 SHALL update PC each rising edge by priority: pc_src -> branch_target; else stall -> hold; else PC+4.
REQ-016 SHALL compute PC+4 modulo 2^N; PC = 2^N-4 wraps to 0.
REQ-017 SHALL update IF/ID by priority: flush or pc_src -> bubble; else stall -> hold; else {PC, imem_data, valid=1}.
REQ-018 SHALL define a bubble as if_id_instr=32'h0, if_id_pc=0, if_id_valid=0; op therefore reads 11'b0.
REQ-019 SHALL give one-cycle latency: instruction at PC p appears on if_id_instr the edge after imem_addr=p.
REQ-020 SHALL let flush and pc_src override stall in the same cycle; stall never blocks a redirect.
REQ-021 SHALL drive op purely from if_id_instr with no added delay.

Reset
REQ-022 SHALL, while reset=0, force PC=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_valid=0, independent of clk.
REQ-023 SHALL, on the first edge after reset deasserts, fetch RESET_PC into IF/ID and advance PC to RESET_PC+4.
REQ-024 SHALL discard any pending redirect or stall asserted in the cycle reset is released mid-operation; state is pure reset value.

Configuration
REQ-025 SHALL, with FETCH_PERF_CNT_EN defined, add outputs fetch_cnt[31:0] (increments each edge a valid instruction loads into IF/ID) and bubble_cnt[31:0] (increments each edge a bubble loads); both wrap at 2^32, reset to 0.
REQ-026 SHALL, without FETCH_PERF_CNT_EN, omit both ports and counters; remaining behaviour identical.

Structure
REQ-027 SHALL place INSTR_W=32, OP_W=11, OP_MSB=31, OP_LSB=21, NOP_INSTR=32'h0 and PC increment constant 4 in shared package fetch_pkg.
REQ-028 SHALL implement PC as one sub-module flopre (N-bit flop, async active-low reset to parameter value, enable); IF/ID logic stays inline.

Verification
REQ-029 SHALL test reset: reset=0 mid-run -> PC=0, if_id_valid=0, op=0 immediately; release, imem returns 32'hF8400000 -> next edge op=11'b11111000010, if_id_pc=0, PC=4.
REQ-030 SHALL test sequential fetch: 4 edges, no stall -> imem_addr 4,8,12,16; if_id_pc lags by one cycle.
REQ-031 SHALL test stall: stall=1 for 3 edges at PC=8 -> PC stays 8, if_id_pc stays 4; release -> PC=12.
REQ-032 SHALL test redirect under stall: stall=1, pc_src=1, branch_target=64'h40 -> PC=64'h40, IF/ID bubble (valid=0, op=0).
REQ-033 SHALL test wrap: force PC=64'hFFFF_FFFF_FFFF_FFFC -> next edge PC=0.
REQ-034 SHALL test counters with FETCH_PERF_CNT_EN: 5 fetches, 2 flushes from reset -> fetch_cnt=5, bubble_cnt=2; build without macro compiles and passes REQ-029..033.
